// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side companion for a non-show-ahead single-clock FIFO. It issues read
// requests, absorbs the FIFO's one-cycle read latency in a small circular
// output buffer, and presents the words as a valid/ready stream. Requests are
// throttled so that the buffer can never overflow, even under backpressure.
// A flush command drains and discards everything queued in the FIFO and in
// the buffer.
//
// Optional feature (compile-time macro FIFO_RD_STREAM_LAST_EN):
//   defined   - a beat counter marks every PKT_LEN-th beat with m_last_o
//   undefined - m_last_o is tied low and no counter is built
//
// Parameters:
//   DW        data width (must match the FIFO)
//   BUF_DEPTH output buffer entries, 2..8
//   PKT_LEN   beats per packet for m_last_o, >= 1
//
// Ports:
//   clk_i         clock
//   arst_n_i      asynchronous active-low reset
//   en_i          permits new FIFO reads while high
//   flush_i       single-cycle pulse that starts a flush
//   fifo_empty_i  FIFO empty flag
//   fifo_valid_i  FIFO read-data valid (one cycle after fifo_req_o)
//   fifo_data_i   FIFO read data
//   fifo_req_o    FIFO read request
//   m_valid_o     stream word valid
//   m_data_o      stream word
//   m_ready_i     consumer ready
//   m_last_o      last beat of a packet
//   busy_o        engine active or buffer holding data
//   flush_done_o  one-cycle pulse when a flush completes
//   proto_err_o   sticky: FIFO returned data with no read in flight
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DW        = 32,
  parameter int BUF_DEPTH = 2,
  parameter int PKT_LEN   = 16
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  input  logic          en_i,
  input  logic          flush_i,
  input  logic          fifo_empty_i,
  input  logic          fifo_valid_i,
  input  logic [DW-1:0] fifo_data_i,
  output logic          fifo_req_o,
  output logic          m_valid_o,
  output logic [DW-1:0] m_data_o,
  input  logic          m_ready_i,
  output logic          m_last_o,
  output logic          busy_o,
  output logic          flush_done_o,
  output logic          proto_err_o
);

  // Elaboration-time guard on the configuration range.
  if ((BUF_DEPTH < 2) || (BUF_DEPTH > 8)) begin : g_bad_buf_depth
    $error("fifo_rd_stream: BUF_DEPTH must be in 2..8");
  end
  if (PKT_LEN < 1) begin : g_bad_pkt_len
    $error("fifo_rd_stream: PKT_LEN must be >= 1");
  end

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // Occupancy arithmetic must hold occ + inflight (up to BUF_DEPTH+1).
  localparam int OW = $clog2(BUF_DEPTH + 2);

  localparam logic [OW-1:0] DEPTH_C  = OW'(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            inflight_q;
  logic            proto_err_q, proto_err_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DW-1:0]   buf_q [BUF_DEPTH];

  logic            req;
  logic            flush_entry;
  logic            flush_done;
  logic            pop;
  logic            push;
  logic [OW-1:0]   occ_proj;

  // Circular pointer advance, wrapping modulo BUF_DEPTH (which need not be a
  // power of two).
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    ptr_next = (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign m_valid_o = (occ_q != '0);
  assign m_data_o  = buf_q[rd_ptr_q];
  assign pop       = m_valid_o && m_ready_i;

  // Occupancy the buffer will have once the in-flight word lands and this
  // cycle's pop leaves. pop implies occ_q >= 1, so the subtraction cannot wrap.
  assign occ_proj  = occ_q + OW'(inflight_q) - OW'(pop);

  // ---------------------------------------------------------------------------
  // Request stage: control FSM and read request generation
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    req         = 1'b0;
    flush_entry = 1'b0;
    flush_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d     = ST_FLUSH;
          flush_entry = 1'b1;
        end else if (en_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Only request when the returned word is guaranteed a buffer slot.
        req = en_i && !fifo_empty_i && (occ_proj < DEPTH_C);
        if (flush_i) begin
          state_d     = ST_FLUSH;
          flush_entry = 1'b1;
        end else if (!en_i && !inflight_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // Drain the FIFO at full rate; returned words are dropped below.
        req = !fifo_empty_i;
        if (fifo_empty_i && !inflight_q) begin
          state_d    = ST_IDLE;
          flush_done = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign fifo_req_o   = req;
  assign flush_done_o = flush_done;
  assign busy_o       = (state_q != ST_IDLE) || m_valid_o;
  assign proto_err_o  = proto_err_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= req;
    end
  end

  // ---------------------------------------------------------------------------
  // Return stage: FIFO read data accepted into the buffer tail
  // ---------------------------------------------------------------------------
  // Words are dropped while flushing (including the entry cycle, whose clear
  // wins). A spurious word that would find no free slot is also dropped so the
  // buffer cannot be corrupted; proto_err_o records the event.
  assign push = fifo_valid_i && (state_q != ST_FLUSH) && !flush_entry &&
                ((occ_q < DEPTH_C) || pop);

  assign proto_err_d = proto_err_q || (fifo_valid_i && !inflight_q);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer stage: circular output buffer, head drives the stream
  // ---------------------------------------------------------------------------
  always_comb begin
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush_entry) begin
      occ_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      occ_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage is reset so that m_data_o reads zero out of reset.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (push) begin
      buf_q[wr_ptr_q] <= fifo_data_i;
    end
  end

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(PKT_LEN - 1);

  logic [BW-1:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (flush_entry) begin
      beat_d = '0;
    end else if (pop) begin
      beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + BW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign m_last_o = m_valid_o && (beat_q == BEAT_LAST);
`else
  assign m_last_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Bench for fifo_rd_stream with a behavioural non-show-ahead FIFO model.
// Words loaded into the FIFO are also queued as expected stream output and
// compared in order as the consumer accepts them.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

  localparam int DW = 32;
  localparam int BD = 2;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          en;
  logic          flush;
  logic          f_empty;
  logic          f_valid;
  logic [DW-1:0] f_data;
  logic          f_req;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          fdone;
  logic          perr;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .DW        (DW),
    .BUF_DEPTH (BD),
    .PKT_LEN   (PL)
  ) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .en_i         (en),
    .flush_i      (flush),
    .fifo_empty_i (f_empty),
    .fifo_valid_i (f_valid),
    .fifo_data_i  (f_data),
    .fifo_req_o   (f_req),
    .m_valid_o    (m_valid),
    .m_data_o     (m_data),
    .m_ready_i    (m_ready),
    .m_last_o     (m_last),
    .busy_o       (busy),
    .flush_done_o (fdone),
    .proto_err_o  (perr)
  );

  int tests = 0;
  int fails = 0;
  int beat = 0;
  int underflows = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];

  logic          s_req, s_valid, s_pop, s_last, s_busy, s_fdone, s_perr;
  logic [DW-1:0] s_data;

  typedef struct {
    int          nwords;
    logic [31:0] base;
    int          stall;
    int          exp_reads;
    logic [31:0] rpat;
  } vec_t;

  vec_t vt[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Non-show-ahead FIFO: a request at edge N presents data during cycle N+1.
  task automatic fifo_model(input logic r);
    if (r) begin
      if (fq.size() == 0) begin
        underflows++;
        f_valid = 1'b0;
      end else begin
        f_data  = fq.pop_front();
        f_valid = 1'b1;
      end
    end else begin
      f_valid = 1'b0;
    end
    f_empty = (fq.size() == 0);
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + DW'(i));
      exp_q.push_back(base + DW'(i));
    end
    f_empty = (fq.size() == 0);
  endtask

  // One clock: sample and score at the falling edge, then advance the FIFO
  // model just after the rising edge. Returns at posedge+1.
  task automatic cycle();
    logic          exp_last;
    logic [DW-1:0] e;
    @(negedge clk);
    s_req   = f_req;
    s_valid = m_valid;
    s_pop   = m_valid && m_ready;
    s_last  = m_last;
    s_busy  = busy;
    s_fdone = fdone;
    s_perr  = perr;
    s_data  = m_data;
    if (s_pop) begin
      check("pop_has_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stream_data", 64'(s_data), 64'(e));
      end
`ifdef FIFO_RD_STREAM_LAST_EN
      exp_last = (beat == PL - 1);
`else
      exp_last = 1'b0;
`endif
      check("m_last", 64'(s_last), 64'(exp_last));
      beat = (beat == PL - 1) ? 0 : beat + 1;
    end
    @(posedge clk);
    #1;
    fifo_model(s_req);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   64'(f_req),   64'd0);
    check({tag, "_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_data"},  64'(m_data),  64'd0);
    check({tag, "_last"},  64'(m_last),  64'd0);
    check({tag, "_busy"},  64'(busy),    64'd0);
    check({tag, "_fdone"}, 64'(fdone),   64'd0);
    check({tag, "_perr"},  64'(perr),    64'd0);
  endtask

  task automatic pulse_reset();
    arst_n = 1'b0;
    beat   = 0;
    exp_q  = fq;
    repeat (2) cycle();
    arst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int fr, fv, lv, nreq, nval, nr, nd, vs, nl;

  initial begin
    vt[0] = '{10, 32'h0000_0100, 20, 2, 32'hFFFF_FFFF};
    vt[1] = '{ 1, 32'h0000_0200,  6, 1, 32'hAAAA_AAAA};
    vt[2] = '{ 7, 32'h0000_0300,  8, 2, 32'h3333_3333};
    vt[3] = '{ 3, 32'h0000_0400,  4, 2, 32'h0F0F_0F0F};

    arst_n  = 1'b0;
    en      = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    f_valid = 1'b0;
    f_data  = '0;
    f_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    arst_n = 1'b1;
    cycle();

    // Preloaded burst, consumer always ready
    load(5, 32'hA0);
    en      = 1'b1;
    m_ready = 1'b1;
    fr = -1; fv = -1; lv = -1; nreq = 0; nval = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_req) begin
        nreq++;
        if (fr < 0) fr = i;
      end
      if (s_valid) begin
        nval++;
        if (fv < 0) fv = i;
        lv = i;
      end
    end
    check("burst_first_req_cycle", 64'(fr), 64'd1);
    check("burst_req_to_valid", 64'(fv - fr), 64'd2);
    check("burst_reads", 64'(nreq), 64'd5);
    check("burst_beats", 64'(nval), 64'd5);
    check("burst_no_bubbles", 64'(lv - fv), 64'd4);
    check("burst_drained", 64'(exp_q.size()), 64'd0);
    check("burst_perr", 64'(s_perr), 64'd0);
    en      = 1'b0;
    m_ready = 1'b0;
    repeat (3) cycle();
    check("burst_idle_busy", 64'(s_busy), 64'd0);

    // Backpressure vectors: stall, count reads, then drain with a ready pattern
    for (int k = 0; k < 4; k++) begin
      load(vt[k].nwords, vt[k].base);
      en      = 1'b1;
      m_ready = 1'b0;
      nr = 0;
      for (int i = 0; i < vt[k].stall; i++) begin
        cycle();
        nr += int'(s_req);
      end
      check("vec_stall_reads", 64'(nr), 64'(vt[k].exp_reads));
      check("vec_held_valid", 64'(s_valid), 64'd1);
      check("vec_held_data", 64'(s_data), 64'(vt[k].base));
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
        m_ready = vt[k].rpat[i % 32];
        cycle();
        nr += int'(s_req);
      end
      check("vec_drained", 64'(exp_q.size()), 64'd0);
      check("vec_total_reads", 64'(nr), 64'(vt[k].nwords));
      en      = 1'b0;
      m_ready = 1'b0;
      repeat (3) cycle();
      check("vec_idle_busy", 64'(s_busy), 64'd0);
    end

    // Flush with 6 words in the FIFO and 2 in the buffer
    load(8, 32'h500);
    en      = 1'b1;
    m_ready = 1'b0;
    repeat (5) cycle();
    check("flush_pre_valid", 64'(s_valid), 64'd1);
    check("flush_pre_fifo_left", 64'(fq.size()), 64'd6);
    flush = 1'b1;
    en    = 1'b0;
    exp_q.delete();
    beat  = 0;
    cycle();
    flush = 1'b0;
    cycle();
    check("flush_valid_drop", 64'(s_valid), 64'd0);
    nd = int'(s_fdone);
    vs = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      nd += int'(s_fdone);
      vs += int'(s_valid);
    end
    check("flush_done_pulses", 64'(nd), 64'd1);
    check("flush_fifo_empty", 64'(fq.size()), 64'd0);
    check("flush_valid_low", 64'(vs), 64'd0);
    check("flush_busy", 64'(s_busy), 64'd0);
    check("flush_perr", 64'(s_perr), 64'd0);

    // Spurious FIFO valid with no read in flight
    f_valid = 1'b1;
    f_data  = 32'hDEAD_BEEF;
    cycle();
    check("perr_not_yet", 64'(s_perr), 64'd0);
    cycle();
    check("perr_set", 64'(s_perr), 64'd1);
    repeat (5) cycle();
    check("perr_sticky", 64'(s_perr), 64'd1);
    arst_n = 1'b0;
    #1;
    check("perr_reset_clears", 64'(perr), 64'd0);
    pulse_reset();

    // Reset mid-stream with the buffer full
    load(6, 32'h600);
    en      = 1'b1;
    m_ready = 1'b0;
    repeat (5) cycle();
    check("rst_pre_valid", 64'(s_valid), 64'd1);
    check("rst_pre_data", 64'(s_data), 64'h600);
    arst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    pulse_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      cycle();
    end
    check("rst_drained", 64'(exp_q.size()), 64'd0);
    en      = 1'b0;
    m_ready = 1'b0;
    repeat (3) cycle();

    // Packet framing over 9 beats with random backpressure
    arst_n = 1'b0;
    #1;
    pulse_reset();
    load(9, 32'h700);
    en = 1'b1;
    nl = 0;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      cycle();
      if (s_pop && s_last) nl++;
    end
    check("pkt_drained", 64'(exp_q.size()), 64'd0);
`ifdef FIFO_RD_STREAM_LAST_EN
    check("pkt_last_count", 64'(nl), 64'd2);
`else
    check("pkt_last_count", 64'(nl), 64'd0);
`endif
    en      = 1'b0;
    m_ready = 1'b0;
    repeat (3) cycle();

    check("no_fifo_underflow", 64'(underflows), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
